// File: rtl/branch_resolve_unit.sv
// Branch resolution for a short in-order pipeline. Prediction metadata follows
// each instruction through the IF/ID and ID/EX slots. In EX the recorded
// prediction is checked against the real outcome. A mismatch squashes the
// younger instructions and redirects fetch. One cycle later the 1-bit
// predictor entry is written, and the resolved-branch and misprediction
// counters saturate instead of wrapping.
module branch_resolve_unit #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [PC_W-1:0]  if_pred_target,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             clr_stats,
    output logic             flush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_en,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // IF/ID slot
    logic            d_valid_q;
    logic [PC_W-1:0] d_pc_q;
    logic            d_pt_q;
    logic [PC_W-1:0] d_ptgt_q;
    // ID/EX slot
    logic            e_valid_q;
    logic [PC_W-1:0] e_pc_q;
    logic            e_pt_q;
    logic [PC_W-1:0] e_ptgt_q;

    logic             upd_en_q,    upd_en_d;
    logic [IDX_W-1:0] upd_idx_q,   upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic [31:0]      branch_cnt_q,  branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic            resolve_s;
    logic            alias_s;
    logic            mispredict_s;
    logic [PC_W-1:0] redirect_pc_s;

    // Detect a wrong prediction for the instruction resolving in EX
    always_comb begin
        resolve_s    = e_valid_q & ~stall;
        // A non-branch that was predicted taken sent fetch down a bogus path.
        alias_s      = ~ex_is_branch & e_pt_q;
        mispredict_s = 1'b0;
        if (resolve_s) begin
            mispredict_s = (ex_is_branch & (e_pt_q != ex_taken))
                         | (ex_is_branch & e_pt_q & ex_taken & (e_ptgt_q != ex_target))
                         | alias_s;
        end else begin
            mispredict_s = 1'b0;
        end
    end

    // Pick the corrected fetch address; held at zero when no redirect is requested
    always_comb begin
        redirect_pc_s = {PC_W{1'b0}};
        if (mispredict_s) begin
            if (ex_is_branch && ex_taken) begin
                redirect_pc_s = ex_target;
            end else begin
                redirect_pc_s = e_pc_q + PC_W'(4);
            end
        end else begin
            redirect_pc_s = {PC_W{1'b0}};
        end
    end

    // Compute next predictor update and saturating counter values
    always_comb begin
        upd_en_d      = resolve_s & (ex_is_branch | alias_s);
        upd_idx_d     = upd_idx_q;
        upd_taken_d   = upd_taken_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en_d) begin
            upd_idx_d   = e_pc_q[IDX_W+1:2];
            upd_taken_d = ex_is_branch & ex_taken;
        end else begin
            upd_idx_d   = upd_idx_q;
            upd_taken_d = upd_taken_q;
        end
        if (clr_stats) begin
            branch_cnt_d  = 32'd0;
            mispred_cnt_d = 32'd0;
        end else begin
            if (resolve_s && ex_is_branch && (branch_cnt_q != CNT_MAX)) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
            if (mispredict_s && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end
    end

    // Advance, hold or squash the metadata slots
    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= {PC_W{1'b0}};
            d_pt_q    <= 1'b0;
            d_ptgt_q  <= {PC_W{1'b0}};
            e_valid_q <= 1'b0;
            e_pc_q    <= {PC_W{1'b0}};
            e_pt_q    <= 1'b0;
            e_ptgt_q  <= {PC_W{1'b0}};
        end else if (mispredict_s) begin
            d_valid_q <= 1'b0;
            e_valid_q <= 1'b0;
        end else if (!stall) begin
            d_valid_q <= if_valid;
            d_pc_q    <= if_pc;
            d_pt_q    <= if_pred_taken;
            d_ptgt_q  <= if_pred_target;
            e_valid_q <= d_valid_q;
            e_pc_q    <= d_pc_q;
            e_pt_q    <= d_pt_q;
            e_ptgt_q  <= d_ptgt_q;
        end else begin
            d_valid_q <= d_valid_q;
            e_valid_q <= e_valid_q;
        end
    end

    // Register predictor write and statistics; reset drops any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_en_q      <= 1'b0;
            upd_idx_q     <= {IDX_W{1'b0}};
            upd_taken_q   <= 1'b0;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            upd_en_q      <= upd_en_d;
            upd_idx_q     <= upd_idx_d;
            upd_taken_q   <= upd_taken_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign flush          = mispredict_s;
    assign redirect_valid = mispredict_s;
    assign redirect_pc    = redirect_pc_s;
    assign upd_en         = upd_en_q;
    assign upd_idx        = upd_idx_q;
    assign upd_taken      = upd_taken_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, stall, if_valid, if_pred_taken;
    logic [31:0] if_pc, if_pred_target;
    logic        ex_is_branch, ex_taken, clr_stats;
    logic [31:0] ex_target;
    logic        flush, redirect_valid, upd_en, upd_taken;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
    logic [5:0]  upd_idx;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.IDX_W(6), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .clr_stats(clr_stats),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction through IF/ID into ID/EX, bubbles behind it
    task automatic send(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
        step();
        if_valid = 1'b0; if_pc = 32'h0; if_pred_taken = 1'b0; if_pred_target = 32'h0;
        step();
    endtask

    task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
        ex_is_branch = br; ex_taken = tk; ex_target = tgt;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = 32'h0;
        if_pred_taken = 1'b0; if_pred_target = 32'h0;
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'h0; clr_stats = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        // Reset state
        check_val("rst_flush", {31'd0, flush}, 32'd0);
        check_val("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check_val("rst_rpc", redirect_pc, 32'd0);
        check_val("rst_upd_en", {31'd0, upd_en}, 32'd0);
        check_val("rst_upd_idx", {26'd0, upd_idx}, 32'd0);
        check_val("rst_bcnt", branch_cnt, 32'd0);
        check_val("rst_mcnt", mispred_cnt, 32'd0);

        // Correct prediction
        send(32'h40, 1'b1, 32'h80);
        set_ex(1'b1, 1'b1, 32'h80);
        check_val("ok_flush", {31'd0, flush}, 32'd0);
        check_val("ok_rv", {31'd0, redirect_valid}, 32'd0);
        step();
        check_val("ok_upd_en", {31'd0, upd_en}, 32'd1);
        check_val("ok_upd_idx", {26'd0, upd_idx}, 32'd16);
        check_val("ok_upd_taken", {31'd0, upd_taken}, 32'd1);
        check_val("ok_bcnt", branch_cnt, 32'd1);
        check_val("ok_mcnt", mispred_cnt, 32'd0);
        step();
        check_val("ok_upd_pulse", {31'd0, upd_en}, 32'd0);

        // Not-taken mispredict with younger instructions in D and arriving in IF
        if_valid = 1'b1; if_pc = 32'h100; if_pred_taken = 1'b1; if_pred_target = 32'h180;
        step();
        if_pc = 32'h500; if_pred_taken = 1'b1; if_pred_target = 32'h900;
        step();
        if_pc = 32'h600;
        set_ex(1'b1, 1'b0, 32'h999);
        check_val("nt_flush", {31'd0, flush}, 32'd1);
        check_val("nt_rv", {31'd0, redirect_valid}, 32'd1);
        check_val("nt_rpc", redirect_pc, 32'h104);
        step();
        if_valid = 1'b0;
        set_ex(1'b0, 1'b0, 32'h0);
        check_val("nt_upd_en", {31'd0, upd_en}, 32'd1);
        check_val("nt_upd_idx", {26'd0, upd_idx}, 32'd0);
        check_val("nt_upd_taken", {31'd0, upd_taken}, 32'd0);
        check_val("nt_mcnt", mispred_cnt, 32'd1);
        check_val("nt_bcnt", branch_cnt, 32'd2);
        check_val("nt_e_squashed", {31'd0, flush}, 32'd0);
        step();
        check_val("nt_d_squashed", {31'd0, flush}, 32'd0);
        check_val("nt_no_upd", {31'd0, upd_en}, 32'd0);

        // Target mismatch
        send(32'h20, 1'b1, 32'h200);
        set_ex(1'b1, 1'b1, 32'h300);
        check_val("tm_flush", {31'd0, flush}, 32'd1);
        check_val("tm_rpc", redirect_pc, 32'h300);
        step();
        check_val("tm_upd_taken", {31'd0, upd_taken}, 32'd1);
        check_val("tm_upd_idx", {26'd0, upd_idx}, 32'd8);
        check_val("tm_mcnt", mispred_cnt, 32'd2);
        check_val("tm_bcnt", branch_cnt, 32'd3);

        // Alias: non-branch predicted taken
        send(32'h8, 1'b1, 32'h44);
        set_ex(1'b0, 1'b0, 32'h1234);
        check_val("al_flush", {31'd0, flush}, 32'd1);
        check_val("al_rpc", redirect_pc, 32'hC);
        step();
        check_val("al_upd_en", {31'd0, upd_en}, 32'd1);
        check_val("al_upd_taken", {31'd0, upd_taken}, 32'd0);
        check_val("al_upd_idx", {26'd0, upd_idx}, 32'd2);
        check_val("al_bcnt", branch_cnt, 32'd3);
        check_val("al_mcnt", mispred_cnt, 32'd3);

        // Plain non-branch, not predicted: nothing happens
        send(32'h10, 1'b0, 32'h0);
        set_ex(1'b0, 1'b0, 32'h0);
        check_val("nb_flush", {31'd0, flush}, 32'd0);
        step();
        check_val("nb_upd_en", {31'd0, upd_en}, 32'd0);
        check_val("nb_mcnt", mispred_cnt, 32'd3);

        // Stall holds a mispredicting branch in E
        send(32'h44, 1'b0, 32'h0);
        set_ex(1'b1, 1'b1, 32'h90);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("st_flush%0d", i), {31'd0, flush}, 32'd0);
            step();
        end
        check_val("st_no_upd", {31'd0, upd_en}, 32'd0);
        check_val("st_bcnt_hold", branch_cnt, 32'd3);
        stall = 1'b0;
        #1;
        check_val("st_flush", {31'd0, flush}, 32'd1);
        check_val("st_rpc", redirect_pc, 32'h90);
        step();
        check_val("st_upd_idx", {26'd0, upd_idx}, 32'd17);
        check_val("st_bcnt", branch_cnt, 32'd4);
        check_val("st_mcnt", mispred_cnt, 32'd4);
        step();
        check_val("st_once_b", branch_cnt, 32'd4);
        check_val("st_once_m", mispred_cnt, 32'd4);

        // PC wrap on fall-through, top index
        send(32'hFFFF_FFFC, 1'b1, 32'h10);
        set_ex(1'b1, 1'b0, 32'h0);
        check_val("wr_rv", {31'd0, redirect_valid}, 32'd1);
        check_val("wr_rpc", redirect_pc, 32'h0);
        step();
        check_val("wr_upd_idx", {26'd0, upd_idx}, 32'd63);

        // Saturation of the misprediction counter
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt_q;
        #1;
        check_val("sat_pre", mispred_cnt, 32'hFFFF_FFFF);
        send(32'h8, 1'b1, 32'h0);
        set_ex(1'b0, 1'b0, 32'h0);
        step();
        check_val("sat_mcnt", mispred_cnt, 32'hFFFF_FFFF);
        check_val("sat_bcnt", branch_cnt, 32'd5);

        // Clear wins over increment
        send(32'h40, 1'b1, 32'h80);
        set_ex(1'b1, 1'b0, 32'h0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check_val("clr_bcnt", branch_cnt, 32'd0);
        check_val("clr_mcnt", mispred_cnt, 32'd0);

        // Reset during an in-flight resolution
        send(32'h40, 1'b1, 32'h80);
        set_ex(1'b1, 1'b1, 32'h80);
        step();
        check_val("mr_pre_bcnt", branch_cnt, 32'd1);
        send(32'h100, 1'b1, 32'h0);
        set_ex(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("mr_upd_en", {31'd0, upd_en}, 32'd0);
        check_val("mr_bcnt", branch_cnt, 32'd0);
        check_val("mr_mcnt", mispred_cnt, 32'd0);
        check_val("mr_flush", {31'd0, flush}, 32'd0);
        step();
        check_val("mr_upd_en2", {31'd0, upd_en}, 32'd0);
        check_val("mr_mcnt2", mispred_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter IDX_W, default 6, predictor table index width (2^IDX_W entries).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, pipeline hold; metadata slots keep their contents while high.
REQ-006 SHALL have port if_valid, input, 1, fetch stage holds a real instruction.
REQ-007 SHALL have port if_pc, input, PC_W, PC of the fetched instruction.
REQ-008 SHALL have port if_pred_taken, input, 1, predictor's taken bit for if_pc.
REQ-009 SHALL have port if_pred_target, input, PC_W, target the fetch stage used when predicted taken.
REQ-010 SHALL have port ex_is_branch, input, 1, EX-stage instruction is a conditional branch.
REQ-011 SHALL have port ex_taken, input, 1, actual branch outcome computed in EX.
REQ-012 SHALL have port ex_target, input, PC_W, actual branch target computed in EX.
REQ-013 SHALL have port clr_stats, input, 1, zero both statistics counters.
REQ-014 SHALL have port flush, output, 1, squash IF/ID and ID/EX pipeline registers.
REQ-015 SHALL have port redirect_valid, output, 1, fetch must load redirect_pc.
REQ-016 SHALL have port redirect_pc, output, PC_W, corrected fetch address.
REQ-017 SHALL have port upd_en, output, 1, write strobe to the 1-bit predictor table.
REQ-018 SHALL have port upd_idx, output, IDX_W, predictor entry to write.
REQ-019 SHALL have port upd_taken, output, 1, value written to that entry.
REQ-020 SHALL have ports branch_cnt and mispred_cnt, outputs, 32 each, resolved-branch and misprediction counts.

Function
REQ-021 SHALL carry per-instruction metadata {valid, pc, pred_taken, pred_target} through two slots, D (IF/ID) and E (ID/EX).
REQ-022 SHALL, on an edge with stall=0 and no flush, load D from if_* inputs (valid=if_valid) and E from D.
REQ-023 SHALL, on an edge with stall=1 and no flush, hold D and E unchanged.
REQ-024 SHALL define resolve = E.valid & ~stall; nothing resolves while stalled or when E is invalid.
REQ-025 SHALL flag a mispredict when resolve and any of: ex_is_branch & (E.pred_taken != ex_taken); ex_is_branch & E.pred_taken & ex_taken & (E.pred_target != ex_target); ~ex_is_branch & E.pred_taken (alias).
REQ-026 SHALL drive flush and redirect_valid combinationally high in the same cycle as a mispredict, low otherwise.
REQ-027 SHALL drive redirect_pc = ex_target when ex_is_branch & ex_taken, else E.pc + 4 (modulo 2^PC_W, wrap permitted); value don't-care when redirect_valid=0.
REQ-028 SHALL, on an edge where flush=1, clear D.valid and E.valid regardless of stall or if_valid.
REQ-029 SHALL register the table update one cycle after resolve: upd_en=1 for exactly one cycle when the resolving instruction had ex_is_branch=1 or was an alias.
REQ-030 SHALL set upd_idx = E.pc[IDX_W+1:2] and upd_taken = ex_taken for branches and 0 for aliases.
REQ-031 SHALL increment branch_cnt on each edge where resolve & ex_is_branch, and mispred_cnt on each mispredict edge.
REQ-032 SHALL saturate both counters at 0xFFFFFFFF (no wrap).
REQ-033 SHALL give clr_stats priority over increment on the same edge; counters become 0.

Reset
REQ-034 SHALL, on an edge with rst=1, clear D.valid, E.valid, upd_en, upd_idx, upd_taken, branch_cnt and mispred_cnt to 0, overriding stall, flush and clr_stats.
REQ-035 SHALL force flush=0 and redirect_valid=0 whenever E.valid=0, hence in the cycle after reset; redirect_pc reset value 0.
REQ-036 SHALL discard an in-flight resolution when rst is asserted mid-operation: no upd_en pulse and no counter change follows.

Verification
REQ-037 Correct predict: branch pc=0x40, pred_taken=1, target 0x80, ex_taken=1, ex_target=0x80 -> flush=0; next cycle upd_en=1, upd_idx=16, upd_taken=1; branch_cnt=1, mispred_cnt=0.
REQ-038 Not-taken mispredict: pc=0x100, pred_taken=1, ex_taken=0 -> flush=1, redirect_pc=0x104 same cycle; D/E valid=0 next edge; upd_taken=0; mispred_cnt=1.
REQ-039 Target mismatch: pc=0x20, pred 0x200 taken, ex_target=0x300 taken -> redirect_pc=0x300; upd_taken=1.
REQ-040 Alias: non-branch pc=0x8 with pred_taken=1 -> redirect_pc=0xC, upd_en=1 upd_taken=0, branch_cnt unchanged, mispred_cnt+1.
REQ-041 Stall: mispredicting branch in E with stall=1 for 3 cycles -> flush=0 throughout; resolves once when stall drops; counters +1 only.
REQ-042 Saturation/clear: preload mispred_cnt=0xFFFFFFFF, mispredict -> stays 0xFFFFFFFF; clr_stats with resolve same edge -> both counters 0.
